// File: rtl/sa_issue_sequencer.sv
// sa_issue_sequencer
//   Walks a two-level loop (SA index outer, element index inner) and issues one
//   (sa, elem) slot per accepted cycle to the systolic-array datapath. The
//   current slot holds while the datapath stalls. After the final slot is
//   accepted, the block waits DRAIN_CYC cycles for pipeline latency, then
//   pulses done for one cycle.
//
//   Handshake: a slot moves from this block to the datapath on a rising edge
//   where issue_valid=1 and stall=0. While stall=1 the slot and indices stay
//   unchanged. stall has no effect outside RUN.
//
// Ports
//   clk, rstn      clock (rising edge), asynchronous active-low reset
//   start          begin a sequence; sampled only in IDLE
//   abort          synchronous cancel from any non-IDLE state
//   cfg_elem_max   last element index (inclusive), latched on start
//   cfg_sa_max     last SA index (inclusive), latched and clamped on start
//   stall          downstream not ready
//   busy           high in every state except IDLE
//   issue_valid    slot on issue_sa/issue_elem is valid (RUN only)
//   issue_sa       current SA index
//   issue_elem     current element index
//   issue_last     current slot is the final slot of the sequence
//   done           one-cycle completion pulse
module sa_issue_sequencer #(
  parameter int SA_NUM    = 4,
  parameter int SA_W      = (SA_NUM > 1) ? $clog2(SA_NUM) : 1,
  parameter int CNT_W     = $clog2(SA_NUM) + 4,
  parameter int DRAIN_CYC = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] cfg_elem_max,
  input  logic [SA_W-1:0]  cfg_sa_max,
  input  logic             stall,
  output logic             busy,
  output logic             issue_valid,
  output logic [SA_W-1:0]  issue_sa,
  output logic [CNT_W-1:0] issue_elem,
  output logic             issue_last,
  output logic             done
);

  localparam int DC_W = $clog2(DRAIN_CYC + 1);
  localparam logic [SA_W-1:0] SA_LAST   = SA_W'(SA_NUM - 1);
  localparam logic [DC_W-1:0] DRAIN_END = DC_W'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] elem_max_q;
  logic [SA_W-1:0]  sa_max_q;
  logic [DC_W-1:0]  drain_cnt;
  logic [SA_W-1:0]  sa_cfg_clamped;
  logic             at_elem_end;
  logic             at_final;

  // Comparison done in int so the clamp stays meaningful when SA_NUM is not
  // a power of two, without a constant-width compare.
  assign sa_cfg_clamped = (int'(cfg_sa_max) > SA_NUM - 1) ? SA_LAST : cfg_sa_max;

  assign at_elem_end = (issue_elem == elem_max_q);
  assign at_final    = at_elem_end && (issue_sa == sa_max_q);

  // Decoded from the registered indices so it lines up with the slot; gated
  // by issue_valid because the indices sit at their maxima during DRAIN.
  assign issue_last  = issue_valid && at_final;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      busy        <= 1'b0;
      issue_valid <= 1'b0;
      done        <= 1'b0;
      issue_sa    <= '0;
      issue_elem  <= '0;
      elem_max_q  <= '0;
      sa_max_q    <= '0;
      drain_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          // start wins over abort here; abort has no meaning in IDLE.
          if (start) begin
            elem_max_q  <= cfg_elem_max;
            sa_max_q    <= sa_cfg_clamped;
            issue_sa    <= '0;
            issue_elem  <= '0;
            state       <= RUN;
            busy        <= 1'b1;
            issue_valid <= 1'b1;
          end
        end
        RUN: begin
          if (abort) begin
            state       <= IDLE;
            busy        <= 1'b0;
            issue_valid <= 1'b0;
            issue_sa    <= '0;
            issue_elem  <= '0;
          end else if (!stall) begin
            if (at_final) begin
              // Indices hold on the final slot.
              state       <= DRAIN;
              issue_valid <= 1'b0;
              drain_cnt   <= '0;
            end else if (at_elem_end) begin
              issue_elem <= '0;
              issue_sa   <= issue_sa + SA_W'(1);
            end else begin
              issue_elem <= issue_elem + CNT_W'(1);
            end
          end
        end
        DRAIN: begin
          if (abort) begin
            state      <= IDLE;
            busy       <= 1'b0;
            issue_sa   <= '0;
            issue_elem <= '0;
            drain_cnt  <= '0;
          end else if (drain_cnt == DRAIN_END) begin
            state     <= DONE;
            done      <= 1'b1;
            drain_cnt <= '0;
          end else begin
            drain_cnt <= drain_cnt + DC_W'(1);
          end
        end
        DONE: begin
          // Always returns to IDLE; abort only additionally clears indices.
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          if (abort) begin
            issue_sa   <= '0;
            issue_elem <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          issue_valid <= 1'b0;
          done        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_issue_sequencer.sv
// Directed bench for sa_issue_sequencer. Inputs are driven on the falling
// edge, outputs are sampled on the falling edge before new inputs are applied.
module tb_sa_issue_sequencer;

  localparam int SA_NUM    = 4;
  localparam int SA_W      = 2;
  localparam int CNT_W     = 6;
  localparam int DRAIN_CYC = 3;
  localparam int SLOT_W    = 1 + SA_W + CNT_W;

  logic             clk;
  logic             rstn;
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] cfg_elem_max;
  logic [SA_W-1:0]  cfg_sa_max;
  logic             stall;
  logic             busy;
  logic             issue_valid;
  logic [SA_W-1:0]  issue_sa;
  logic [CNT_W-1:0] issue_elem;
  logic             issue_last;
  logic             done;

  logic [SLOT_W-1:0] exp_q[$];
  int total;
  int bad;

  sa_issue_sequencer #(
    .SA_NUM   (SA_NUM),
    .SA_W     (SA_W),
    .CNT_W    (CNT_W),
    .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .abort       (abort),
    .cfg_elem_max(cfg_elem_max),
    .cfg_sa_max  (cfg_sa_max),
    .stall       (stall),
    .busy        (busy),
    .issue_valid (issue_valid),
    .issue_sa    (issue_sa),
    .issue_elem  (issue_elem),
    .issue_last  (issue_last),
    .done        (done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  busy,        0);
    check({tag, "_valid"}, issue_valid, 0);
    check({tag, "_done"},  done,        0);
    check({tag, "_last"},  issue_last,  0);
  endtask

  // Called on a falling edge; start is seen by the following rising edge.
  task automatic do_start(input int em, input int sm);
    start        = 1'b1;
    cfg_elem_max = CNT_W'(em);
    cfg_sa_max   = SA_W'(sm);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full sequence with optional stalls on two slot numbers (slen cycles each)
  // and an optional mid-RUN start pulse plus cfg change at slot 1.
  task automatic run_check(input int em, input int sm_drv, input int sm_eff,
                           input int sl_a, input int sl_b, input int slen,
                           input bit poke);
    int n;
    int exp_run;
    int run_cyc;
    int idx;
    int held;
    int cyc;
    exp_q.delete();
    for (int s = 0; s <= sm_eff; s++)
      for (int e = 0; e <= em; e++)
        exp_q.push_back({(s == sm_eff && e == em), SA_W'(s), CNT_W'(e)});
    n = exp_q.size();
    exp_run = n + ((sl_a >= 0 && sl_a < n) ? slen : 0) + ((sl_b >= 0 && sl_b < n) ? slen : 0);
    do_start(em, sm_drv);
    run_cyc = 0; idx = 0; held = 0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 300) begin
      check("run_valid", issue_valid, 1);
      check("run_busy",  busy,        1);
      check("run_done",  done,        0);
      check("slot", {issue_last, issue_sa, issue_elem}, exp_q[0]);
      run_cyc++;
      if (poke && idx == 1 && held == 0) begin
        start        = 1'b1;
        cfg_elem_max = '0;
        cfg_sa_max   = '0;
      end else begin
        start = 1'b0;
      end
      if ((idx == sl_a || idx == sl_b) && held < slen) begin
        stall = 1'b1;
        held++;
      end else begin
        stall = 1'b0;
        held  = 0;
        void'(exp_q.pop_front());
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    stall = 1'b0;
    start = 1'b0;
    check("slots_left", exp_q.size(), 0);
    check("run_cycles", run_cyc, exp_run);
    for (int i = 0; i < DRAIN_CYC; i++) begin
      check("drain_valid", issue_valid, 0);
      check("drain_last",  issue_last,  0);
      check("drain_busy",  busy,        1);
      check("drain_done",  done,        0);
      stall = 1'b1;  // ignored during DRAIN
      @(negedge clk);
    end
    stall = 1'b0;
    check("done_pulse", done, 1);
    check("done_busy",  busy, 1);
    start = 1'b1;    // ignored during DONE
    @(negedge clk);
    start = 1'b0;
    check_idle("after_done");
    @(negedge clk);
    check_idle("stay_idle");
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rstn  = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    stall = 1'b0;
    cfg_elem_max = '0;
    cfg_sa_max   = '0;
    #12;
    check_idle("reset");
    check("reset_sa",   issue_sa,   0);
    check("reset_elem", issue_elem, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // T1: 4 x 2 slots, no stall
    run_check(3, 1, 1, -1, -1, 0, 1'b0);
    // T2: stall slots 2 and 5 for 2 cycles each
    run_check(3, 1, 1, 2, 5, 2, 1'b0);
    // T3: single slot
    run_check(0, 0, 0, -1, -1, 0, 1'b0);
    // T4: cfg_sa_max=7 truncates to the 2-bit field (3 = SA_NUM-1); poke mid-run
    run_check(1, 7, 3, -1, -1, 0, 1'b1);

    // abort in IDLE: no effect; abort together with start in IDLE: start wins
    abort = 1'b1;
    @(negedge clk);
    check_idle("abort_idle");
    start = 1'b1;
    cfg_elem_max = 6'd3;
    cfg_sa_max   = 2'd1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("abort_start_busy",  busy,        1);
    check("abort_start_valid", issue_valid, 1);
    // T5: advance to slot (0,2) then abort
    @(negedge clk);
    @(negedge clk);
    check("pre_abort_slot", {issue_last, issue_sa, issue_elem}, {1'b0, 2'd0, 6'd2});
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort_run");
    check("abort_sa",   issue_sa,   0);
    check("abort_elem", issue_elem, 0);
    for (int i = 0; i < 6; i++) begin
      check("abort_no_done", done, 0);
      @(negedge clk);
    end
    run_check(3, 1, 1, -1, -1, 0, 1'b0);

    // T6: reset during DRAIN
    do_start(3, 0);
    repeat (4) @(negedge clk);
    check("pre_rst_valid", issue_valid, 0);
    check("pre_rst_busy",  busy,        1);
    rstn = 1'b0;
    #1;
    check_idle("async_rst");
    check("async_rst_sa",   issue_sa,   0);
    check("async_rst_elem", issue_elem, 0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_done", done, 0);
      check("rst_no_busy", busy, 0);
    end
    run_check(2, 1, 1, 0, -1, 1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
